// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_reg_slave
// Brief    : AXI4-Lite register bank of NUM_REGS 32-bit registers with byte
//            strobes, per-register commit pulses and independent W/R FSMs.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_reg_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,

    input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,

    output logic [32*NUM_REGS-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    localparam int         c_IDX_W       = $clog2(NUM_REGS);
    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rstate_t;

    wstate_t                       r_wstate;
    wstate_t                       w_wstate_nxt;
    rstate_t                       r_rstate;
    rstate_t                       w_rstate_nxt;

    logic                          r_aw_held;
    logic                          r_w_held;
    logic [ADDR_WIDTH-1:2]         r_awaddr;
    logic [31:0]                   r_wdata;
    logic [3:0]                    r_wstrb;

    logic                          r_bvalid;
    logic [1:0]                    r_bresp;
    logic                          r_rvalid;
    logic [1:0]                    r_rresp;
    logic [31:0]                   r_rdata;
    logic [NUM_REGS-1:0]           r_wr_pulse;

    logic                          w_awready;
    logic                          w_wready;
    logic                          w_arready;
    logic                          w_aw_hs;
    logic                          w_w_hs;
    logic                          w_ar_hs;
    logic                          w_aw_oor;
    logic                          w_ar_oor;
    logic [c_IDX_W-1:0]            w_aw_idx;
    logic [c_IDX_W-1:0]            w_ar_idx;
    logic                          w_commit;
    logic [NUM_REGS-1:0]           w_wr_sel;
    logic [NUM_REGS-1:0][31:0]     w_regs;
    logic                          w_unused_addr_lsbs;

    // Byte-offset bits carry no meaning for a word-only register bank.
    assign w_unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign w_aw_idx = r_awaddr[c_IDX_W+1:2];
    assign w_ar_idx = S_AXI_ARADDR[c_IDX_W+1:2];

    generate
        if (ADDR_WIDTH > c_IDX_W + 2) begin : g_range_chk
            assign w_aw_oor = |r_awaddr[ADDR_WIDTH-1:c_IDX_W+2];
            assign w_ar_oor = |S_AXI_ARADDR[ADDR_WIDTH-1:c_IDX_W+2];
        end else begin : g_no_range_chk
            assign w_aw_oor = 1'b0;
            assign w_ar_oor = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = !r_aw_held;
                w_wready  = !r_w_held;
                if ((r_aw_held || S_AXI_AWVALID) && (r_w_held || S_AXI_WVALID)) begin
                    w_wstate_nxt = W_COMMIT;
                end
            end
            W_COMMIT: begin
                w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                if (r_bvalid && S_AXI_BREADY) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: begin
                w_wstate_nxt = W_IDLE;
            end
        endcase
        // The only input-to-output path: reset gates the READYs.
        if (rst) begin
            w_awready = 1'b0;
            w_wready  = 1'b0;
        end
    end

    assign w_aw_hs  = S_AXI_AWVALID && w_awready;
    assign w_w_hs   = S_AXI_WVALID && w_wready;
    assign w_commit = (r_wstate == W_COMMIT) && !w_aw_oor;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (r_wstate == W_COMMIT) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bvalid <= 1'b0;
            r_bresp  <= c_RESP_OKAY;
        end else if (r_wstate == W_COMMIT) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_aw_oor ? c_RESP_SLVERR : c_RESP_OKAY;
        end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
            logic [31:0] r_val;

            assign w_wr_sel[k] = w_commit && (w_aw_idx == c_IDX_W'(k));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_val <= '0;
                end else if (w_wr_sel[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (r_wstrb[b]) begin
                            r_val[8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                    end
                end
            end

            assign w_regs[k] = r_val;
        end
    endgenerate

    // Pulse fires on commit even when no strobe bit is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_wr_sel;
        end
    end

    // ------------------------------------------------------------------
    // Read channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = 1'b1;
                if (S_AXI_ARVALID) begin
                    w_rstate_nxt = R_RESP;
                end
            end
            R_RESP: begin
                if (r_rvalid && S_AXI_RREADY) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: begin
                w_rstate_nxt = R_IDLE;
            end
        endcase
        if (rst) begin
            w_arready = 1'b0;
        end
    end

    assign w_ar_hs = S_AXI_ARVALID && w_arready;

    // Sampled at the AR edge, so a same-edge commit is not visible here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rresp  <= c_RESP_OKAY;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_ar_oor ? c_RESP_SLVERR : c_RESP_OKAY;
            r_rdata  <= w_ar_oor ? 32'h0 : w_regs[w_ar_idx];
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;
    assign regs_flat     = w_regs;
    assign wr_pulse      = r_wr_pulse;

endmodule
`default_nettype wire

// File: doc/axi_lite_reg_slave.md
# axi_lite_reg_slave

AXI4-Lite slave register bank that terminates the transactions issued by our `axi_master` block. It sits directly downstream of the master on the same AXI4-Lite bus and holds NUM_REGS 32-bit read/write registers with byte-strobe writes. It also exposes every register's contents, plus a one-cycle write strobe per register, to the surrounding fabric. Write and read channels are served by independent state machines.

## Interface
- ADDR_WIDTH, 32, width of AWADDR/ARADDR
- NUM_REGS, 8, number of 32-bit registers; power of two, 2..64
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables; bit i covers WDATA[8i+7:8i]
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response: OKAY / SLVERR
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- regs_flat  out  32*NUM_REGS  register contents; reg k at [32k+31:32k]
- wr_pulse  out  NUM_REGS  bit k high one cycle when reg k is committed

## Operation
- Decode: index = addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored; any nonzero bit in addr[ADDR_WIDTH-1:log2(NUM_REGS)+2] = out of range.
- Write FSM states: W_IDLE, W_COMMIT, W_RESP.
- W_IDLE: AWREADY = !aw_held, WREADY = !w_held; AW and W are accepted independently in either order or in the same cycle; address, data and strobe are latched on their handshake.
- W_IDLE -> W_COMMIT on the edge at which both aw_held and w_held become (or are) set.
- W_COMMIT (1 cycle): in range -> bytes with WSTRB=1 updated, others kept, wr_pulse[index]=1 even if WSTRB=0, BRESP=OKAY. Out of range -> no register changes, no pulse, BRESP=SLVERR. BVALID set; held flags cleared; -> W_RESP.
- W_RESP: AWREADY=WREADY=0; BVALID/BRESP held stable until BREADY; on BVALID&&BREADY -> W_IDLE.
- Read FSM states: R_IDLE, R_RESP.
- R_IDLE: ARREADY=1. On handshake: RDATA = reg[index] (OKAY), or 0 with SLVERR if out of range; RVALID=1; -> R_RESP.
- R_RESP: ARREADY=0; RDATA/RRESP/RVALID stable until RREADY; on RVALID&&RREADY -> R_IDLE.
- Read and write FSMs are fully independent; simultaneous read and write of the same register both proceed.

## Timing
- Reset (rst high at an edge): all registers 0, regs_flat=0, wr_pulse=0, BVALID=RVALID=0, BRESP=RRESP=00, RDATA=0, held flags cleared, FSMs -> idle; AWREADY/WREADY/ARREADY forced 0 while rst is high, 1 in the first cycle after release.
- Reset mid-transaction aborts it: pending AW/W discarded, outstanding B/R response dropped, no register write.
- Write latency: final of AW/W handshakes at edge N -> register updated, wr_pulse and BVALID high after edge N+1. Minimum write cycle: 3 cycles with BREADY held high.
- Read latency: AR handshake at edge N -> RVALID/RDATA valid after edge N. Back-to-back read every 2 cycles with RREADY high.
- Read/write collision: RDATA is sampled at the AR handshake; a commit to the same register at the same edge is not visible (old value returned).
- BREADY/RREADY may rise any number of cycles after VALID (our master raises them one cycle late); the slave must not drop VALID before the handshake.
- No combinational path from any input to any output except the rst gating of the READY outputs.

## Test plan
- Reset, then write 0xDEADBEEF to addr 0x04 with WSTRB=4'hF, AW and W in the same cycle -> BRESP=00 three cycles later, wr_pulse[1] one cycle, read 0x04 returns 0xDEADBEEF with RRESP=00.
- W presented 3 cycles before AW, then AW 2 cycles before W, to addr 0x08 -> single commit per transaction, correct data, AWREADY/WREADY low in W_RESP.
- Reg 2 = 0x11223344, write 0xAABBCCDD with WSTRB=4'b0101 -> reads 0x11BB33DD; WSTRB=0 -> value unchanged, wr_pulse[2] still fires.
- Write/read addr 0x40 (NUM_REGS=8) -> BRESP=10, no register or wr_pulse change; RDATA=0, RRESP=10.
- Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and data stable, no new AW/AR accepted; concurrent read of reg 3 during commit to reg 3 returns old value.
- Assert rst while in W_RESP with BVALID high and in R_RESP -> next cycle BVALID=RVALID=0, all registers 0, READYs high after release.
